// File: rtl/axi_bridge_pkg.sv
// Shared types and constants for the AXI burst bridge.
// FSM state enums, AXI encodings and the burst length clamp.
package axi_bridge_pkg;

  typedef enum logic {
    RD_IDLE,
    RD_AR
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } wr_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [7:0] clamp_len(
    input logic [7:0] len,
    input logic [7:0] max_len
  );
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// The pointer moves past the winner only when advance is high.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    int idx;
    int nxt;
    idx   = 0;
    nxt   = int'(ptr_q);
    grant = '0;
    // Walk backwards so the port closest to the pointer wins.
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (req[PW'(idx)]) begin
        grant          = '0;
        grant[PW'(idx)] = 1'b1;
        nxt            = (idx == N - 1) ? 0 : idx + 1;
      end
    end
    ptr_d = (advance && (|grant)) ? PW'(nxt) : ptr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/axi_burst_bridge.sv
// Bridges cache read ports and one write port onto AXI bursts.
// Reads wait while a write is outstanding, except on its B beat.
module axi_burst_bridge
  import axi_bridge_pkg::*;
#(
  parameter int NUM_RD    = 2,
  parameter int DATA_W    = 128,
  parameter int ID_W      = 4,
  parameter int MAX_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD-1:0]           rd_req,
  input  logic [NUM_RD*32-1:0]        rd_addr,
  input  logic [NUM_RD*8-1:0]         rd_len,
  output logic [NUM_RD-1:0]           rd_rdy,
  output logic [NUM_RD-1:0]           ret_valid,
  output logic [NUM_RD-1:0]           ret_last,
  output logic [DATA_W-1:0]           ret_data,
  input  logic                        wr_req,
  input  logic [31:0]                 wr_addr,
  input  logic [7:0]                  wr_len,
  input  logic [DATA_W/8-1:0]         wr_strb,
  input  logic [DATA_W*MAX_BEATS-1:0] wr_data,
  output logic                        wr_rdy,
  output logic                        wr_done,
  output logic                        wr_err,
  output logic                        write_buffer_empty,
  output logic [ID_W-1:0]             arid,
  output logic [31:0]                 araddr,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [ID_W-1:0]             rid,
  input  logic [DATA_W-1:0]           rdata,
  input  logic [1:0]                  rresp,
  input  logic                        rlast,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [ID_W-1:0]             awid,
  output logic [31:0]                 awaddr,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [DATA_W-1:0]           wdata,
  output logic [DATA_W/8-1:0]         wstrb,
  output logic                        wlast,
  output logic                        wvalid,
  input  logic                        wready,
  input  logic [ID_W-1:0]             bid,
  input  logic [1:0]                  bresp,
  input  logic                        bvalid,
  output logic                        bready
);

  localparam logic [2:0] AX_SIZE = 3'($clog2(DATA_W / 8));
  localparam logic [7:0] LEN_MAX = 8'(MAX_BEATS - 1);
  localparam int         BW      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int         WB_W    = DATA_W * MAX_BEATS;

  rd_state_e             rd_state_q, rd_state_d;
  logic [31:0]           araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [ID_W-1:0]       arid_q, arid_d;
  logic                  arvalid_q, arvalid_d;

  wr_state_e             wr_state_q, wr_state_d;
  logic [WB_W-1:0]       wbuf_q, wbuf_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [7:0]            wlen_q, wlen_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  wr_done_q, wr_done_d;
  logic                  wr_err_q, wr_err_d;

  logic [NUM_RD-1:0]     rd_elig;
  logic [NUM_RD-1:0]     rd_grant;
  logic                  b_hs;
  logic                  rd_ok;
  logic                  aw_done;
  logic                  w0_done;
  logic [7:0]            wr_len_c;
  logic [BW-1:0]         beat_sel;
  logic [DATA_W-1:0]     beat_slice [MAX_BEATS];
  logic                  unused_in;

  assign unused_in = ^{rresp, bid};

  assign b_hs    = (wr_state_q == W_RESP) && bvalid;
  assign rd_ok   = (wr_state_q == W_IDLE) || b_hs;
  assign rd_elig = (rd_state_q == RD_IDLE && rd_ok) ? rd_req : '0;

  rr_arbiter #(
    .N(NUM_RD)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rd_elig),
    .advance (|rd_grant),
    .grant   (rd_grant)
  );

  assign rd_rdy  = rd_grant;
  assign rready  = ~reset;
  assign bready  = ~reset;
  assign arid    = arid_q;
  assign araddr  = araddr_q;
  assign arlen   = arlen_q;
  assign arsize  = AX_SIZE;
  assign arburst = BURST_INCR;
  assign arvalid = arvalid_q;

  always_comb begin
    ret_valid = '0;
    ret_last  = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ret_valid[i] = rvalid && (rid == ID_W'(i));
      ret_last[i]  = rvalid && rlast && (rid == ID_W'(i));
    end
  end

  assign ret_data = rdata;

  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arid_d     = arid_q;
    arvalid_d  = arvalid_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (|rd_grant) begin
          for (int i = 0; i < NUM_RD; i++) begin
            if (rd_grant[i]) begin
              araddr_d = rd_addr[i*32 +: 32];
              arlen_d  = clamp_len(rd_len[i*8 +: 8], LEN_MAX);
              arid_d   = ID_W'(i);
            end
          end
          arvalid_d  = 1'b1;
          rd_state_d = RD_AR;
        end
      end
      RD_AR: begin
        if (arready) begin
          arvalid_d  = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  for (genvar k = 0; k < MAX_BEATS; k++) begin : g_slice
    assign beat_slice[k] = wbuf_q[k*DATA_W +: DATA_W];
  end

  // Beat 0 goes out in W_ADDR; W_DATA streams beats 1..len.
  assign beat_sel = (wr_state_q == W_DATA) ? BW'(cnt_q + 8'd1) : '0;
  assign wdata    = beat_slice[beat_sel];
  assign wstrb    = wstrb_q;
  assign wlast    = wlast_q;
  assign wvalid   = wvalid_q;

  assign awid     = ID_W'(NUM_RD);
  assign awaddr   = awaddr_q;
  assign awlen    = wlen_q;
  assign awsize   = AX_SIZE;
  assign awburst  = BURST_INCR;
  assign awvalid  = awvalid_q;

  assign wr_rdy             = (wr_state_q == W_IDLE);
  assign write_buffer_empty = (wr_state_q == W_IDLE);
  assign wr_done            = wr_done_q;
  assign wr_err             = wr_err_q;

  assign wr_len_c = clamp_len(wr_len, LEN_MAX);
  assign aw_done  = !awvalid_q || awready;
  assign w0_done  = !wvalid_q || wready;

  always_comb begin
    wr_state_d = wr_state_q;
    wbuf_d     = wbuf_q;
    wstrb_d    = wstrb_q;
    wlen_d     = wlen_q;
    awaddr_d   = awaddr_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    cnt_d      = cnt_q;
    wr_done_d  = 1'b0;
    wr_err_d   = wr_err_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (wr_req) begin
          wbuf_d     = wr_data;
          wstrb_d    = wr_strb;
          wlen_d     = wr_len_c;
          awaddr_d   = wr_addr;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          wlast_d    = (wr_len_c == 8'd0);
          cnt_d      = 8'd0;
          wr_state_d = W_ADDR;
        end
      end
      W_ADDR: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        if (aw_done && w0_done) begin
          if (wlen_q == 8'd0) begin
            wr_state_d = W_RESP;
          end else begin
            wvalid_d   = 1'b1;
            wlast_d    = (wlen_q == 8'd1);
            wr_state_d = W_DATA;
          end
        end
      end
      W_DATA: begin
        if (wready) begin
          if (wlast_q) begin
            wvalid_d   = 1'b0;
            wlast_d    = 1'b0;
            wr_state_d = W_RESP;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            wlast_d = (cnt_q + 8'd2 == wlen_q);
          end
        end
      end
      W_RESP: begin
        if (bvalid) begin
          wr_done_d  = 1'b1;
          if (bresp != RESP_OKAY) wr_err_d = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q <= RD_IDLE;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arid_q     <= '0;
      arvalid_q  <= 1'b0;
      wr_state_q <= W_IDLE;
      wbuf_q     <= '0;
      wstrb_q    <= '0;
      wlen_q     <= '0;
      awaddr_q   <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      cnt_q      <= '0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arid_q     <= arid_d;
      arvalid_q  <= arvalid_d;
      wr_state_q <= wr_state_d;
      wbuf_q     <= wbuf_d;
      wstrb_q    <= wstrb_d;
      wlen_q     <= wlen_d;
      awaddr_q   <= awaddr_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      cnt_q      <= cnt_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_bridge.sv
// Directed bench for axi_burst_bridge.
// Covers arbitration, read return, write bursts, errors and reset.
module tb_axi_burst_bridge;

  localparam int NUM_RD    = 2;
  localparam int DATA_W    = 128;
  localparam int ID_W      = 4;
  localparam int MAX_BEATS = 4;

  logic                        clk = 1'b0;
  logic                        reset;
  logic [NUM_RD-1:0]           rd_req;
  logic [NUM_RD*32-1:0]        rd_addr;
  logic [NUM_RD*8-1:0]         rd_len;
  logic [NUM_RD-1:0]           rd_rdy;
  logic [NUM_RD-1:0]           ret_valid;
  logic [NUM_RD-1:0]           ret_last;
  logic [DATA_W-1:0]           ret_data;
  logic                        wr_req;
  logic [31:0]                 wr_addr;
  logic [7:0]                  wr_len;
  logic [DATA_W/8-1:0]         wr_strb;
  logic [DATA_W*MAX_BEATS-1:0] wr_data;
  logic                        wr_rdy;
  logic                        wr_done;
  logic                        wr_err;
  logic                        write_buffer_empty;
  logic [ID_W-1:0]             arid;
  logic [31:0]                 araddr;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;
  logic                        arvalid;
  logic                        arready;
  logic [ID_W-1:0]             rid;
  logic [DATA_W-1:0]           rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;
  logic [ID_W-1:0]             awid;
  logic [31:0]                 awaddr;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;
  logic                        awvalid;
  logic                        awready;
  logic [DATA_W-1:0]           wdata;
  logic [DATA_W/8-1:0]         wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;
  logic [ID_W-1:0]             bid;
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  int errors = 0;
  int checks = 0;

  axi_burst_bridge #(
    .NUM_RD(NUM_RD), .DATA_W(DATA_W),
    .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
    .ret_data(ret_data), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_len(wr_len), .wr_strb(wr_strb), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_done(wr_done), .wr_err(wr_err),
    .write_buffer_empty(write_buffer_empty),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] slice_of(input int k);
    return {4{32'hA5A5_0000 + 32'(k)}};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbeats;
    int naw;
    logic [3:0] lastmask;
    logic [127:0] beat_data [4];

    reset   = 1'b1;
    rd_req  = '0;
    rd_addr = '0;
    rd_len  = '0;
    wr_req  = 1'b0;
    wr_addr = '0;
    wr_len  = '0;
    wr_strb = '0;
    wr_data = '0;
    arready = 1'b0;
    rid     = '0;
    rdata   = '0;
    rresp   = '0;
    rlast   = 1'b0;
    rvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bid     = '0;
    bresp   = '0;
    bvalid  = 1'b0;
    for (int k = 0; k < MAX_BEATS; k++)
      wr_data[k*128 +: 128] = slice_of(k);

    tick;
    tick;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_wlast", wlast, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_wr_rdy", wr_rdy, 1);
    chk("rst_wbe", write_buffer_empty, 1);
    chk("rst_rready", rready, 0);
    chk("arburst", arburst, 2'b01);
    chk("arsize", arsize, 3'd4);
    chk("awburst", awburst, 2'b01);
    chk("awsize", awsize, 3'd4);
    chk("awid", awid, 4'd2);

    reset = 1'b0;
    tick;
    chk("rready", rready, 1);
    chk("bready", bready, 1);

    // round-robin between two always-requesting ports
    rd_addr = {32'h0000_2000, 32'h0000_1000};
    rd_len  = {8'd1, 8'd1};
    arready = 1'b1;
    rd_req  = 2'b11;
    #1;
    chk("gnt_a0", rd_rdy, 2'b01);
    tick;
    chk("ar_a_valid", arvalid, 1);
    chk("ar_a_id", arid, 0);
    chk("ar_a_addr", araddr, 32'h1000);
    chk("ar_a_len", arlen, 1);
    chk("rdy_in_ar", rd_rdy, 2'b00);
    tick;
    chk("gnt_b1", rd_rdy, 2'b10);
    tick;
    chk("ar_b_id", arid, 1);
    chk("ar_b_addr", araddr, 32'h2000);
    tick;
    chk("gnt_c0", rd_rdy, 2'b01);
    tick;
    chk("ar_c_id", arid, 0);
    tick;
    chk("gnt_d1", rd_rdy, 2'b10);
    tick;
    chk("ar_d_id", arid, 1);
    rd_req = 2'b00;
    tick;
    chk("ar_d_clr", arvalid, 0);

    // read length clamp and AR hold while arready is low
    rd_addr[31:0] = 32'h0000_1040;
    rd_len[7:0]   = 8'd9;
    arready = 1'b0;
    rd_req  = 2'b01;
    #1;
    chk("gnt_clamp", rd_rdy, 2'b01);
    tick;
    rd_req = 2'b00;
    chk("clamp_arlen", arlen, 3);
    chk("clamp_arid", arid, 0);
    tick;
    chk("hold_arvalid", arvalid, 1);
    chk("hold_araddr", araddr, 32'h1040);
    arready = 1'b1;
    tick;
    chk("hold_release", arvalid, 0);
    arready = 1'b0;

    // four-beat R return to port 1
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1;
      rid    = 4'd1;
      rdata  = {96'h0, 32'hD000_0000 + 32'(k)};
      rlast  = (k == 3);
      #1;
      chk("ret_valid_p1", ret_valid, 2'b10);
      chk("ret_last_p1", ret_last, (k == 3) ? 2'b10 : 2'b00);
      chk("ret_data", ret_data, {96'h0, 32'hD000_0000 + 32'(k)});
      tick;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    #1;
    chk("ret_idle", ret_valid, 2'b00);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rid    = 4'd0;
    #1;
    chk("ret_valid_p0", ret_valid, 2'b01);
    chk("ret_last_p0", ret_last, 2'b01);
    rvalid = 1'b0;
    rlast  = 1'b0;
    tick;

    // four-beat write, awready delayed 3 cycles
    wr_strb = 16'h0FF0;
    wready  = 1'b1;
    awready = 1'b0;
    wr_addr = 32'h0000_4000;
    wr_len  = 8'd3;
    wr_req  = 1'b1;
    #1;
    chk("wr_rdy_idle", wr_rdy, 1);
    tick;
    wr_req = 1'b0;
    chk("aw_valid", awvalid, 1);
    chk("aw_addr", awaddr, 32'h4000);
    chk("aw_len", awlen, 3);
    chk("w_strb", wstrb, 16'h0FF0);
    chk("wbe_busy", write_buffer_empty, 0);
    chk("wr_rdy_busy", wr_rdy, 0);
    nbeats   = 0;
    naw      = 0;
    lastmask = '0;
    for (int cyc = 0; cyc < 20 && nbeats < 4; cyc++) begin
      awready = (cyc >= 3);
      #1;
      if (awvalid && awready) naw++;
      if (wvalid && wready) begin
        beat_data[nbeats] = wdata;
        if (wlast) lastmask[nbeats] = 1'b1;
        nbeats++;
      end
      if (nbeats < 4) tick;
    end
    awready = 1'b0;
    chk("w_beats", 32'(nbeats), 4);
    chk("aw_count", 32'(naw), 1);
    chk("w_lastmask", lastmask, 4'b1000);
    for (int k = 0; k < 4; k++)
      chk("w_slice", beat_data[k], slice_of(k));
    tick;
    chk("resp_wvalid", wvalid, 0);
    chk("resp_wbe", write_buffer_empty, 0);
    bvalid = 1'b1;
    bresp  = 2'b00;
    #1;
    chk("done_early", wr_done, 0);
    tick;
    bvalid = 1'b0;
    chk("done_pulse", wr_done, 1);
    chk("done_idle", wr_rdy, 1);
    chk("okay_err", wr_err, 0);
    tick;
    chk("done_clear", wr_done, 0);

    // single-beat write, read blocked until B, SLVERR response
    awready = 1'b1;
    wready  = 1'b1;
    wr_addr = 32'h0000_4100;
    wr_len  = 8'd0;
    wr_req  = 1'b1;
    #1;
    tick;
    wr_req        = 1'b0;
    rd_addr[31:0] = 32'h0000_1080;
    rd_len[7:0]   = 8'd2;
    rd_req        = 2'b01;
    #1;
    chk("blk_addr", rd_rdy, 2'b00);
    chk("single_wlast", wlast, 1);
    chk("single_wdata", wdata, slice_of(0));
    tick;
    chk("single_wvalid", wvalid, 0);
    chk("blk_resp_a", rd_rdy, 2'b00);
    tick;
    chk("blk_resp_b", rd_rdy, 2'b00);
    chk("blk_arvalid", arvalid, 0);
    bvalid = 1'b1;
    bresp  = 2'b10;
    #1;
    chk("unblk_bvalid", rd_rdy, 2'b01);
    tick;
    bvalid = 1'b0;
    bresp  = 2'b00;
    rd_req = 2'b00;
    chk("ar_after_b", arvalid, 1);
    chk("ar_after_b_addr", araddr, 32'h1080);
    chk("ar_after_b_len", arlen, 2);
    chk("err_done", wr_done, 1);
    chk("err_set", wr_err, 1);
    arready = 1'b1;
    tick;
    chk("ar_after_b_clr", arvalid, 0);
    repeat (3) tick;
    chk("err_sticky", wr_err, 1);

    // concurrent accept, write clamp, reset during W_DATA
    arready       = 1'b0;
    rd_addr[63:32] = 32'h0000_3000;
    rd_len[15:8]  = 8'd0;
    rd_req        = 2'b10;
    wr_addr       = 32'h0000_5000;
    wr_len        = 8'd200;
    wr_req        = 1'b1;
    #1;
    chk("conc_rd_rdy", rd_rdy, 2'b10);
    chk("conc_wr_rdy", wr_rdy, 1);
    tick;
    rd_req = 2'b00;
    wr_req = 1'b0;
    chk("conc_arvalid", arvalid, 1);
    chk("conc_arid", arid, 1);
    chk("conc_awvalid", awvalid, 1);
    chk("wclamp_awlen", awlen, 3);
    chk("conc_wdata0", wdata, slice_of(0));
    tick;
    chk("wd_beat1", wdata, slice_of(1));
    chk("wd_beat1_last", wlast, 0);
    tick;
    chk("wd_beat2", wdata, slice_of(2));
    chk("wd_beat2_valid", wvalid, 1);
    reset = 1'b1;
    #1;
    chk("mrst_arvalid", arvalid, 0);
    chk("mrst_awvalid", awvalid, 0);
    chk("mrst_wvalid", wvalid, 0);
    chk("mrst_wlast", wlast, 0);
    chk("mrst_wr_err", wr_err, 0);
    chk("mrst_wr_done", wr_done, 0);
    chk("mrst_wbe", write_buffer_empty, 1);
    chk("mrst_wr_rdy", wr_rdy, 1);
    tick;
    reset = 1'b0;
    tick;
    chk("post_wr_rdy", wr_rdy, 1);
    chk("post_wvalid", wvalid, 0);
    chk("post_arvalid", arvalid, 0);
    chk("post_rready", rready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
